// File: rtl/secuenciador_conversion_operandos_pkg.sv
// Shared definitions for the calculator operand path.
//   - State encoding of the operand-conversion sequencer (4-bit localparams).
//   - Error codes reported alongside listo.
//   - Largest 5-digit BCD value that still fits in 16 bits.
package pkg_calculadora;

    localparam logic [3:0] REPOSO     = 4'd0;
    localparam logic [3:0] VALIDAR    = 4'd1;
    localparam logic [3:0] LANZAR_A   = 4'd2;
    localparam logic [3:0] ESPERAR_A  = 4'd3;
    localparam logic [3:0] LIBERAR_A  = 4'd4;
    localparam logic [3:0] LANZAR_B   = 4'd5;
    localparam logic [3:0] ESPERAR_B  = 4'd6;
    localparam logic [3:0] LIBERAR_B  = 4'd7;
    localparam logic [3:0] FIN_OK     = 4'd8;
    localparam logic [3:0] FIN_ERROR  = 4'd9;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_DIGITO = 2'b01;
    localparam logic [1:0] ERR_RANGO  = 2'b10;
    localparam logic [1:0] ERR_TIEMPO = 2'b11;

    localparam logic [19:0] BCD_MAX_16 = 20'h65535;

    // States in which the converter handshake is pending and the timeout runs.
    function automatic logic es_fase_conversion(input logic [3:0] estado);
        return (estado == LANZAR_A)  || (estado == ESPERAR_A) || (estado == LIBERAR_A) ||
               (estado == LANZAR_B)  || (estado == ESPERAR_B) || (estado == LIBERAR_B);
    endfunction

endpackage

// File: rtl/secuenciador_conversion_operandos_validador.sv
// Combinational check of one 5-digit BCD operand.
//   bcd             in  20  operand, [19:16] most significant digit
//   digito_invalido out 1   some nibble is above 9
//   fuera_rango     out 1   digits are valid but the value exceeds 65535
module validador_bcd_operando
    import pkg_calculadora::*;
(
    input  logic [19:0] bcd,
    output logic        digito_invalido,
    output logic        fuera_rango
);

    always_comb begin
        digito_invalido = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                digito_invalido = 1'b1;
            end
        end
        // With every nibble in 0..9, a plain magnitude compare of the BCD vector orders
        // exactly like the digit-wise decimal compare against 6,5,5,3,5.
        fuera_rango = !digito_invalido && (bcd > BCD_MAX_16);
    end

endmodule

// File: rtl/secuenciador_conversion_operandos.sv
// Sequences a single shared BCD-to-binary converter over operands A and B.
//   reloj, reset (sync, active-high)
//   inicio, operando_a_bcd, operando_b_bcd            request from entry logic
//   ocupado, listo, error_codigo                       status (registered)
//   operando_a_bin, operando_b_bin                     results, updated on successful listo
//   conv_inicio, conv_entrada_bcd                      converter command
//   conv_resultado_bin, conv_terminado                 converter response
module secuenciador_conversion_operandos
    import pkg_calculadora::*;
#(
    parameter int unsigned TIEMPO_MAX = 64
) (
    input  logic        reloj,
    input  logic        reset,
    input  logic        inicio,
    input  logic [19:0] operando_a_bcd,
    input  logic [19:0] operando_b_bcd,
    output logic        ocupado,
    output logic        listo,
    output logic [1:0]  error_codigo,
    output logic [15:0] operando_a_bin,
    output logic [15:0] operando_b_bin,
    output logic        conv_inicio,
    output logic [19:0] conv_entrada_bcd,
    input  logic [15:0] conv_resultado_bin,
    input  logic        conv_terminado
);

    localparam int unsigned AnchoCnt = $clog2(TIEMPO_MAX) + 1;
    // Leaving the phase when the counter would step to TIEMPO_MAX-1 lands listo exactly
    // TIEMPO_MAX cycles after the phase was entered.
    localparam logic [AnchoCnt-1:0] CntLimite = AnchoCnt'(TIEMPO_MAX - 2);

    logic [3:0]          estado_q, estado_d;
    logic [AnchoCnt-1:0] cnt_q, cnt_d;
    logic [19:0]         op_a_q, op_a_d, op_b_q, op_b_d;
    logic [15:0]         temp_a_q, temp_a_d, temp_b_q, temp_b_d;
    logic [15:0]         bin_a_q, bin_a_d, bin_b_q, bin_b_d;
    logic [19:0]         entrada_q, entrada_d;
    logic [1:0]          error_q, error_d;
    logic                ocupado_q, ocupado_d;
    logic                listo_q, listo_d;
    logic                conv_inicio_q, conv_inicio_d;

    logic inv_a, inv_b, rango_a, rango_b;
    logic tiempo_agotado;

    validador_bcd_operando u_valida_a (
        .bcd             (op_a_q),
        .digito_invalido (inv_a),
        .fuera_rango     (rango_a)
    );

    validador_bcd_operando u_valida_b (
        .bcd             (op_b_q),
        .digito_invalido (inv_b),
        .fuera_rango     (rango_b)
    );

    assign tiempo_agotado = es_fase_conversion(estado_q) && (cnt_q == CntLimite);

    always_comb begin
        estado_d      = estado_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        temp_a_d      = temp_a_q;
        temp_b_d      = temp_b_q;
        bin_a_d       = bin_a_q;
        bin_b_d       = bin_b_q;
        entrada_d     = entrada_q;
        error_d       = error_q;
        listo_d       = 1'b0;
        conv_inicio_d = 1'b0;

        case (estado_q)
            REPOSO: begin
                // A request arriving in the listo cycle is dropped, not queued.
                if (inicio && !listo_q) begin
                    op_a_d   = operando_a_bcd;
                    op_b_d   = operando_b_bcd;
                    error_d  = ERR_OK;
                    estado_d = VALIDAR;
                end
            end
            VALIDAR: begin
                if (inv_a || inv_b) begin
                    error_d  = ERR_DIGITO;
                    estado_d = FIN_ERROR;
                end else if (rango_a || rango_b) begin
                    error_d  = ERR_RANGO;
                    estado_d = FIN_ERROR;
                end else begin
                    entrada_d = op_a_q;
                    estado_d  = LANZAR_A;
                end
            end
            LANZAR_A, LANZAR_B: begin
                if (tiempo_agotado) begin
                    error_d  = ERR_TIEMPO;
                    estado_d = FIN_ERROR;
                end else if (!conv_terminado) begin
                    // A stale done from a previous conversion holds us here.
                    conv_inicio_d = 1'b1;
                    estado_d      = (estado_q == LANZAR_A) ? ESPERAR_A : ESPERAR_B;
                end
            end
            ESPERAR_A, ESPERAR_B: begin
                if (tiempo_agotado) begin
                    error_d  = ERR_TIEMPO;
                    estado_d = FIN_ERROR;
                end else if (conv_terminado) begin
                    if (estado_q == ESPERAR_A) begin
                        temp_a_d = conv_resultado_bin;
                        estado_d = LIBERAR_A;
                    end else begin
                        temp_b_d = conv_resultado_bin;
                        estado_d = LIBERAR_B;
                    end
                end
            end
            LIBERAR_A, LIBERAR_B: begin
                if (tiempo_agotado) begin
                    error_d  = ERR_TIEMPO;
                    estado_d = FIN_ERROR;
                end else if (!conv_terminado) begin
                    if (estado_q == LIBERAR_A) begin
                        entrada_d = op_b_q;
                        estado_d  = LANZAR_B;
                    end else begin
                        estado_d  = FIN_OK;
                    end
                end
            end
            FIN_OK: begin
                bin_a_d  = temp_a_q;
                bin_b_d  = temp_b_q;
                listo_d  = 1'b1;
                estado_d = REPOSO;
            end
            FIN_ERROR: begin
                listo_d  = 1'b1;
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        if ((estado_d != estado_q) || !es_fase_conversion(estado_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + AnchoCnt'(1);
        end

        ocupado_d = (estado_d != REPOSO);
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            estado_q      <= REPOSO;
            cnt_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            temp_a_q      <= '0;
            temp_b_q      <= '0;
            bin_a_q       <= '0;
            bin_b_q       <= '0;
            entrada_q     <= '0;
            error_q       <= ERR_OK;
            ocupado_q     <= 1'b0;
            listo_q       <= 1'b0;
            conv_inicio_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            cnt_q         <= cnt_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            temp_a_q      <= temp_a_d;
            temp_b_q      <= temp_b_d;
            bin_a_q       <= bin_a_d;
            bin_b_q       <= bin_b_d;
            entrada_q     <= entrada_d;
            error_q       <= error_d;
            ocupado_q     <= ocupado_d;
            listo_q       <= listo_d;
            conv_inicio_q <= conv_inicio_d;
        end
    end

    assign ocupado          = ocupado_q;
    assign listo            = listo_q;
    assign error_codigo     = error_q;
    assign operando_a_bin   = bin_a_q;
    assign operando_b_bin   = bin_b_q;
    assign conv_inicio      = conv_inicio_q;
    assign conv_entrada_bcd = entrada_q;

endmodule

// File: tb/tb_secuenciador_conversion_operandos.sv
// Bench for secuenciador_conversion_operandos: a converter stub with configurable latency,
// done-hold length or silence; directed transactions push expectations into a queue that a
// listo monitor pops and compares.
module tb_secuenciador_conversion_operandos;

    logic        reloj = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b0;
    logic [19:0] operando_a_bcd = '0;
    logic [19:0] operando_b_bcd = '0;
    logic        ocupado, listo, conv_inicio;
    logic [1:0]  error_codigo;
    logic [15:0] operando_a_bin, operando_b_bin;
    logic [19:0] conv_entrada_bcd;
    logic [15:0] conv_resultado_bin;
    logic        conv_terminado;

    always #5 reloj = ~reloj;

    secuenciador_conversion_operandos #(.TIEMPO_MAX(64)) dut (
        .reloj              (reloj),
        .reset              (reset),
        .inicio             (inicio),
        .operando_a_bcd     (operando_a_bcd),
        .operando_b_bcd     (operando_b_bcd),
        .ocupado            (ocupado),
        .listo              (listo),
        .error_codigo       (error_codigo),
        .operando_a_bin     (operando_a_bin),
        .operando_b_bin     (operando_b_bin),
        .conv_inicio        (conv_inicio),
        .conv_entrada_bcd   (conv_entrada_bcd),
        .conv_resultado_bin (conv_resultado_bin),
        .conv_terminado     (conv_terminado)
    );

    int comparados = 0;
    int fallos     = 0;

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        comparados++;
        if (actual !== esperado) begin
            fallos++;
            $display("FAIL %s: got %0h, expected %0h", nombre, actual, esperado);
        end
    endtask

    // ---------------- converter stub ----------------
    // The sequencer first samples terminado=1 lat_conv rising edges after the edge that
    // raised conv_inicio; terminado then stays high for hold_conv cycles.
    int lat_conv  = 18;
    int hold_conv = 1;
    bit nunca     = 1'b0;
    int m_cnt, m_hold;
    bit m_pend;

    function automatic logic [15:0] bcd_a_bin(input logic [19:0] v);
        return 16'(v[19:16] * 10000 + v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0]);
    endfunction

    always @(posedge reloj) begin
        if (reset) begin
            m_pend             <= 1'b0;
            m_cnt              <= 0;
            m_hold             <= 0;
            conv_terminado     <= 1'b0;
            conv_resultado_bin <= '0;
        end else if (conv_inicio) begin
            m_pend <= !nunca;
            m_cnt  <= lat_conv - 2;
        end else if (m_pend) begin
            if (m_cnt <= 1) begin
                m_pend             <= 1'b0;
                conv_terminado     <= 1'b1;
                conv_resultado_bin <= bcd_a_bin(conv_entrada_bcd);
                m_hold             <= hold_conv;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (conv_terminado) begin
            if (m_hold <= 1) conv_terminado <= 1'b0;
            else m_hold <= m_hold - 1;
        end
    end

    int n_pulsos = 0;
    always @(negedge reloj) begin
        if (!reset && conv_inicio) n_pulsos++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  err;
        logic [15:0] a;
        logic [15:0] b;
    } esperado_t;

    esperado_t sb_q[$];

    always @(negedge reloj) begin
        if (!reset && listo) begin
            if (sb_q.size() == 0) begin
                comparados++;
                fallos++;
                $display("FAIL listo_inesperado: got listo=1, expected none");
            end else begin
                esperado_t e;
                e = sb_q.pop_front();
                chk("error_codigo", 32'(error_codigo), 32'(e.err));
                chk("operando_a_bin", 32'(operando_a_bin), 32'(e.a));
                chk("operando_b_bin", 32'(operando_b_bin), 32'(e.b));
            end
        end
    end

    // Issues one request from a negedge and waits for listo; ends one negedge after listo.
    task automatic transaccion(input logic [19:0] a, input logic [19:0] b, input logic [1:0] err,
                               input logic [15:0] ea, input logic [15:0] eb,
                               input int lat_esp, input int pulsos_esp);
        esperado_t e;
        int n, p0;
        e.err = err;
        e.a   = ea;
        e.b   = eb;
        sb_q.push_back(e);
        p0 = n_pulsos;
        operando_a_bcd = a;
        operando_b_bcd = b;
        inicio = 1'b1;
        @(negedge reloj);
        inicio = 1'b0;
        n = 0;
        while (!listo && n < 300) begin
            @(negedge reloj);
            n++;
        end
        chk("latencia", 32'(n), 32'(lat_esp));
        chk("pulsos_conv_inicio", 32'(n_pulsos - p0), 32'(pulsos_esp));
        @(negedge reloj);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0;
        esperado_t e;
        repeat (3) @(negedge reloj);
        reset = 1'b0;
        chk("reset_ocupado", 32'(ocupado), 0);
        chk("reset_listo", 32'(listo), 0);
        chk("reset_error", 32'(error_codigo), 0);
        chk("reset_a_bin", 32'(operando_a_bin), 0);
        chk("reset_b_bin", 32'(operando_b_bin), 0);
        chk("reset_conv_inicio", 32'(conv_inicio), 0);
        chk("reset_conv_entrada", 32'(conv_entrada_bcd), 0);

        // Success: 1 + 2*(1+18+1) + 1 = 42.
        transaccion(20'h12345, 20'h00042, 2'b00, 16'h3039, 16'h002A, 42, 2);
        // Invalid digit in A: no conversion, results kept.
        transaccion(20'h1A345, 20'h00042, 2'b01, 16'h3039, 16'h002A, 2, 0);
        repeat (3) @(negedge reloj);
        chk("error_retenido", 32'(error_codigo), 32'(2'b01));
        // Upper boundary of the range check.
        transaccion(20'h65535, 20'h00000, 2'b00, 16'hFFFF, 16'h0000, 42, 2);
        transaccion(20'h65536, 20'h00001, 2'b10, 16'hFFFF, 16'h0000, 2, 0);
        // Faults on operand B.
        transaccion(20'h00001, 20'h0000F, 2'b01, 16'hFFFF, 16'h0000, 2, 0);
        transaccion(20'h00000, 20'h99999, 2'b10, 16'hFFFF, 16'h0000, 2, 0);

        // Silent converter: ESPERAR_A entered 2 cycles after inicio, listo 64 later.
        nunca = 1'b1;
        transaccion(20'h00007, 20'h00008, 2'b11, 16'hFFFF, 16'h0000, 66, 1);
        nunca = 1'b0;

        // Done held as a level for 5 cycles: 1 + 2*(1+18+5) + 1 = 50.
        hold_conv = 5;
        transaccion(20'h00100, 20'h65535, 2'b00, 16'h0064, 16'hFFFF, 50, 2);
        hold_conv = 1;

        // Reset while waiting for B.
        p0 = n_pulsos;
        operando_a_bcd = 20'h11111;
        operando_b_bcd = 20'h22222;
        inicio = 1'b1;
        @(negedge reloj);
        inicio = 1'b0;
        n = 0;
        while (n_pulsos < p0 + 2 && n < 300) begin
            @(negedge reloj);
            n++;
        end
        chk("alcanza_esperar_b", 32'(n_pulsos - p0), 2);
        repeat (3) @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        reset = 1'b0;
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_listo", 32'(listo), 0);
        chk("rst_error", 32'(error_codigo), 0);
        chk("rst_a_bin", 32'(operando_a_bin), 0);
        chk("rst_b_bin", 32'(operando_b_bin), 0);
        chk("rst_conv_inicio", 32'(conv_inicio), 0);
        chk("rst_conv_entrada", 32'(conv_entrada_bcd), 0);
        @(negedge reloj);

        // Extra inicio pulses while busy are dropped: 1 + 2*(1+4+1) + 1 = 14.
        lat_conv = 4;
        e.err = 2'b00;
        e.a   = 16'h000A;
        e.b   = 16'h0014;
        sb_q.push_back(e);
        p0 = n_pulsos;
        operando_a_bcd = 20'h00010;
        operando_b_bcd = 20'h00020;
        inicio = 1'b1;
        @(negedge reloj);
        inicio = 1'b0;
        n = 0;
        while (!listo && n < 300) begin
            if (n == 2 || n == 6 || n == 10) inicio = 1'b1;
            else inicio = 1'b0;
            @(negedge reloj);
            n++;
        end
        chk("latencia_ignora", 32'(n), 14);
        chk("pulsos_ignora", 32'(n_pulsos - p0), 2);
        // Request in the listo cycle must not start anything.
        inicio = 1'b1;
        @(negedge reloj);
        inicio = 1'b0;
        chk("inicio_en_listo", 32'(ocupado), 0);
        repeat (5) @(negedge reloj);
        chk("pulsos_total_ignora", 32'(n_pulsos - p0), 2);
        chk("cola_vacia", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
        $finish;
    end

endmodule
